// File: rtl/host_bridge_pkg.sv
// Shared definitions for the FX2 GPIF host bridge: waveform state codes,
// mode and rdy bit positions, and the single-register-read phase type.
package host_bridge_pkg;

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SETEP    = 4'd1;
  localparam logic [3:0] ST_SETADDR  = 4'd2;
  localparam logic [3:0] ST_WRDATA   = 4'd3;
  localparam logic [3:0] ST_RDDATA   = 4'd4;
  localparam logic [3:0] ST_SETMODE  = 4'd5;
  localparam logic [3:0] ST_GETRVAL  = 4'd6;
  localparam logic [3:0] ST_SETTC_LO = 4'd7;
  localparam logic [3:0] ST_SETTC_HI = 4'd8;

  localparam int MODE_AUTOINC = 0;
  localparam int RDY_DATA     = 0;
  localparam int RDY_ERR      = 1;

  // GETRVAL: request the register first, then transfer it on rdwr
  typedef enum logic {PH_REQ, PH_XFER} rval_phase_e;

endpackage

// File: rtl/host_prefetch_fifo.sv
// Synchronous prefetch FIFO for block reads; flush wins over push and pop.
module host_prefetch_fifo #(
  parameter  int DW    = 16,
  parameter  int DEPTH = 4,
  localparam int PW    = $clog2(DEPTH),
  localparam int CW    = PW + 1
) (
  input  logic          ifclk,
  input  logic          resetb,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] head,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full
);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));

  // NOTE: the storage array has no reset; only pointers and count do, since
  // a slot is never read before it has been written.
  always_ff @(posedge ifclk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

  // Pointers wrap naturally because DEPTH is a power of two
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

endmodule

// File: rtl/host_bridge_prefetch.sv
// FX2 GPIF to device-interface bridge with a prefetching block-read path,
// address auto-increment, wide transfer count and sticky underrun flag.
module host_bridge_prefetch
  import host_bridge_pkg::*;
#(
  parameter int DW    = 16,
  parameter int AW    = 16,
  parameter int TC_W  = 32,
  parameter int DEPTH = 4
) (
  input  logic          ifclk,
  input  logic          resetb,
  input  logic [2:0]    ctl,
  input  logic [3:0]    state,
  output logic [1:0]    rdy,
  input  logic [DW-1:0] data_i,
  output logic [DW-1:0] data_o,
  output logic          data_oe,
  output logic [AW-1:0] di_term_addr,
  output logic [AW-1:0] di_reg_addr,
  output logic [DW-1:0] di_reg_datai,
  input  logic [DW-1:0] di_reg_datao,
  output logic          di_read_req,
  output logic          di_read,
  input  logic          di_read_rdy,
  output logic          di_write,
  input  logic          di_write_rdy
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [3:0]      state_r;
  logic [2:0]      ctl_r;
  logic [DW-1:0]   din_r;
  logic            rdwr;
  logic            active;
  logic            mode;
  logic [TC_W-1:0] tc;
  logic [TC_W-1:0] tc_reload;
  logic [TC_W-1:0] tc_left;
  rval_phase_e     phase;
  rval_phase_e     phase_nxt;
  logic            pf_inflight;   // di_read currently high on behalf of the prefetcher
  logic            pf_issue;
  logic            in_rd;
  logic            flush;
  logic            pop;
  logic            underrun;
  logic            nonempty_nxt;
  logic [DW-1:0]   head;
  logic [CW-1:0]   count;
  logic            empty;
  logic            full;

  assign rdwr   = ctl_r[1];
  assign active = ctl_r[2];

  host_prefetch_fifo #(.DW(DW), .DEPTH(DEPTH)) u_fifo (
    .ifclk  (ifclk),
    .resetb (resetb),
    .push   (pf_inflight),
    .pop    (pop),
    .flush  (flush),
    .wdata  (di_reg_datao),
    .head   (head),
    .count  (count),
    .empty  (empty),
    .full   (full)
  );

  // NOTE: every always_comb output gets a default before any branch so no
  // path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    in_rd    = (state_r == ST_RDDATA);
    flush    = !(in_rd && active);
    pop      = in_rd && active && rdwr && !empty;
    underrun = in_rd && active && rdwr && empty;
    // The read in flight has not reached tc or the FIFO yet; count it here
    tc_left  = tc - TC_W'(pf_inflight);
    pf_issue = in_rd && active && di_read_rdy && !full && (tc_left != '0) &&
               ((count + CW'(pf_inflight)) < CW'(DEPTH));
    nonempty_nxt = !flush && ((count + CW'(pf_inflight) - CW'(pop)) != '0);
    phase_nxt = phase;
    if (state_r != ST_GETRVAL)                phase_nxt = PH_REQ;
    else if (phase == PH_REQ && di_read_rdy)  phase_nxt = PH_XFER;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // right-hand side sees the pre-edge value regardless of statement order.
  always_ff @(posedge ifclk or negedge resetb) begin
    if (!resetb) begin
      state_r      <= ST_IDLE;
      ctl_r        <= '0;
      din_r        <= '0;
      phase        <= PH_REQ;
      mode         <= 1'b1;
      tc           <= '0;
      tc_reload    <= '0;
      pf_inflight  <= 1'b0;
      rdy          <= '0;
      data_o       <= '0;
      data_oe      <= 1'b0;
      di_term_addr <= '0;
      di_reg_addr  <= '0;
      di_reg_datai <= '0;
      di_read_req  <= 1'b0;
      di_read      <= 1'b0;
      di_write     <= 1'b0;
    end else begin
      state_r     <= state;
      ctl_r       <= ctl;
      din_r       <= data_i;
      phase       <= phase_nxt;
      di_read_req <= 1'b0;
      di_read     <= 1'b0;
      di_write    <= 1'b0;
      pf_inflight <= 1'b0;

      // Effects of the strobe presented during the cycle just ending
      if ((di_read || di_write) && mode) di_reg_addr <= di_reg_addr + 1'b1;
      if (pf_inflight && tc != '0)       tc <= tc - 1'b1;
      if (underrun)                      rdy[RDY_ERR] <= 1'b1;

      unique case (state_r)
        ST_SETEP: begin
          rdy[RDY_DATA] <= 1'b1;
          data_oe       <= 1'b0;
          if (rdwr) begin
            di_term_addr <= din_r[AW-1:0];
            rdy[RDY_ERR] <= 1'b0;
          end
        end
        ST_SETADDR: begin
          rdy[RDY_DATA] <= 1'b1;
          data_oe       <= 1'b0;
          if (rdwr) di_reg_addr <= din_r[AW-1:0];
        end
        ST_SETMODE: begin
          rdy[RDY_DATA] <= 1'b1;
          data_oe       <= 1'b0;
          if (rdwr) mode <= din_r[MODE_AUTOINC];
        end
        ST_SETTC_LO: begin
          rdy[RDY_DATA] <= 1'b1;
          data_oe       <= 1'b0;
          if (rdwr) begin
            tc_reload[DW-1:0] <= din_r;
            tc[DW-1:0]        <= din_r;
          end
        end
        ST_SETTC_HI: begin
          rdy[RDY_DATA] <= 1'b1;
          data_oe       <= 1'b0;
          if (rdwr) begin
            tc_reload[TC_W-1:DW] <= din_r[TC_W-DW-1:0];
            tc[TC_W-1:DW]        <= din_r[TC_W-DW-1:0];
          end
        end
        ST_WRDATA: begin
          di_reg_datai  <= din_r;
          di_write      <= rdwr;
          rdy[RDY_DATA] <= di_write_rdy;
          data_oe       <= 1'b0;
        end
        ST_GETRVAL: begin
          data_oe <= 1'b1;
          if (phase == PH_REQ) begin
            rdy[RDY_DATA] <= 1'b0;
            di_read_req   <= di_read_rdy;
          end else begin
            di_read       <= rdwr;
            rdy[RDY_DATA] <= di_read_rdy;
            if (di_read) data_o <= di_reg_datao;
          end
        end
        ST_RDDATA: begin
          data_oe       <= 1'b1;
          di_read       <= pf_issue;
          pf_inflight   <= pf_issue;
          rdy[RDY_DATA] <= nonempty_nxt;
          if (!active) tc <= tc_reload;
          if (pop)     data_o <= head;
        end
        default: begin
          rdy[RDY_DATA] <= 1'b0;
          data_oe       <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_host_bridge_prefetch.sv
// Directed bench for host_bridge_prefetch with a queue-based scoreboard and
// a simple terminal model that returns 0xB000 + read index on each di_read.
module tb_host_bridge_prefetch;
  import host_bridge_pkg::*;

  logic        ifclk = 1'b0;
  logic        resetb;
  logic [2:0]  ctl;
  logic [3:0]  state;
  logic [1:0]  rdy;
  logic [15:0] data_i;
  logic [15:0] data_o;
  logic        data_oe;
  logic [15:0] di_term_addr;
  logic [15:0] di_reg_addr;
  logic [15:0] di_reg_datai;
  logic [15:0] di_reg_datao;
  logic        di_read_req;
  logic        di_read;
  logic        di_read_rdy;
  logic        di_write;
  logic        di_write_rdy;

  typedef struct packed {logic [15:0] data; logic [15:0] addr;} wr_exp_t;

  wr_exp_t     wr_q[$];
  logic [15:0] exp_q[$];
  int          checks = 0;
  int          errors = 0;
  int          rd_cnt = 0;
  int          req_cnt = 0;
  int          overlap_cnt = 0;
  logic [15:0] rd_idx = '0;
  logic        rd_pending = 1'b0;
  logic [15:0] prev_do = '0;
  logic        in_block = 1'b0;

  assign di_reg_datao = 16'hB000 + rd_idx;

  host_bridge_prefetch #(.DW(16), .AW(16), .TC_W(32), .DEPTH(4)) dut (
    .ifclk        (ifclk),
    .resetb       (resetb),
    .ctl          (ctl),
    .state        (state),
    .rdy          (rdy),
    .data_i       (data_i),
    .data_o       (data_o),
    .data_oe      (data_oe),
    .di_term_addr (di_term_addr),
    .di_reg_addr  (di_reg_addr),
    .di_reg_datai (di_reg_datai),
    .di_reg_datao (di_reg_datao),
    .di_read_req  (di_read_req),
    .di_read      (di_read),
    .di_read_rdy  (di_read_rdy),
    .di_write     (di_write),
    .di_write_rdy (di_write_rdy)
  );

  always #5 ifclk = ~ifclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge ifclk);
  endtask

  // Scoreboard side: observes the DUT at negedge, away from the active edge
  task automatic monitor();
    wr_exp_t e;
    forever begin
      @(negedge ifclk);
      if (di_read_req && di_read) overlap_cnt++;
      if (di_read_req) req_cnt++;
      if (di_write) begin
        if (wr_q.size() == 0) check("wr_queue_size", wr_q.size(), 1);
        else begin
          e = wr_q.pop_front();
          check("wr_data", di_reg_datai, e.data);
          check("wr_addr", di_reg_addr, e.addr);
        end
      end
      if (in_block && data_o !== prev_do) begin
        if (exp_q.size() == 0) check("rd_queue_size", exp_q.size(), 1);
        else check("rd_word", data_o, exp_q.pop_front());
      end
      prev_do = data_o;
      // Terminal model: data stays stable through the read cycle's posedge
      if (rd_pending) rd_idx = rd_idx + 1'b1;
      rd_pending = di_read;
      if (di_read) begin
        rd_cnt++;
        if (in_block) exp_q.push_back(16'hB000 + rd_idx);
      end
    end
  endtask

  task automatic host_write(input logic [3:0] st, input logic [15:0] val);
    state = st; data_i = val; ctl = 3'b110; cyc(1);
    ctl = 3'b100; cyc(1);
    state = ST_IDLE; ctl = 3'b000; cyc(2);
  endtask

  task automatic getrval_read();
    state = ST_GETRVAL; ctl = 3'b100; cyc(3);
    ctl = 3'b110; cyc(1);
    ctl = 3'b100; cyc(3);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_rdy"}, rdy, 0);
    check({tag, "_data_o"}, data_o, 0);
    check({tag, "_data_oe"}, data_oe, 0);
    check({tag, "_term"}, di_term_addr, 0);
    check({tag, "_addr"}, di_reg_addr, 0);
    check({tag, "_datai"}, di_reg_datai, 0);
    check({tag, "_strobes"}, {di_read_req, di_read, di_write}, 0);
  endtask

  initial begin
    int snap;
    int req_snap;
    wr_exp_t w;
    resetb = 1'b0; ctl = '0; state = ST_IDLE; data_i = '0;
    di_read_rdy = 1'b1; di_write_rdy = 1'b1;
    fork monitor(); join_none
    #1 check_all_zero("por");
    cyc(2); resetb = 1'b1; cyc(2);

    // Setup and single register read
    host_write(ST_SETEP, 16'h0005);
    host_write(ST_SETADDR, 16'h0010);
    check("term_addr", di_term_addr, 16'h0005);
    req_snap = req_cnt; snap = rd_cnt;
    getrval_read();
    check("rval_req_pulses", req_cnt - req_snap, 1);
    check("rval_reads", rd_cnt - snap, 1);
    check("rval_data", data_o, 16'hB000);
    check("rval_addr", di_reg_addr, 16'h0011);
    check("rval_oe", data_oe, 1);
    check("rval_rdy0", rdy[0], 1);
    state = ST_IDLE; ctl = '0; cyc(2);

    // Block write, auto-increment off then on
    host_write(ST_SETADDR, 16'h0010);
    host_write(ST_SETMODE, 16'h0000);
    for (int i = 0; i < 4; i++) begin
      w.data = 16'h00A0 + 16'(i); w.addr = 16'h0010; wr_q.push_back(w);
    end
    state = ST_WRDATA; ctl = 3'b110;
    for (int i = 0; i < 4; i++) begin data_i = 16'h00A0 + 16'(i); cyc(1); end
    ctl = 3'b100; cyc(1); state = ST_IDLE; ctl = '0; cyc(3);
    check("wr_all_seen", wr_q.size(), 0);
    check("wr_addr_held", di_reg_addr, 16'h0010);
    host_write(ST_SETMODE, 16'h0001);
    host_write(ST_SETADDR, 16'h0020);
    w.data = 16'h1234; w.addr = 16'h0020; wr_q.push_back(w);
    w.data = 16'h5678; w.addr = 16'h0021; wr_q.push_back(w);
    state = ST_WRDATA; ctl = 3'b110;
    data_i = 16'h1234; cyc(1); data_i = 16'h5678; cyc(1);
    ctl = 3'b100; cyc(1); state = ST_IDLE; ctl = '0; cyc(3);
    check("wr_inc_all_seen", wr_q.size(), 0);
    check("wr_inc_addr", di_reg_addr, 16'h0022);

    // Block read of 10 words with a 3-cycle di_read_rdy stall
    host_write(ST_SETADDR, 16'h0100);
    host_write(ST_SETTC_LO, 16'd10);
    host_write(ST_SETTC_HI, 16'd0);
    in_block = 1'b1; snap = rd_cnt;
    state = ST_RDDATA; ctl = 3'b000; cyc(2);
    ctl = 3'b110; cyc(4);
    di_read_rdy = 1'b0; cyc(3);
    di_read_rdy = 1'b1; cyc(30);
    check("blk_reads", rd_cnt - snap, 10);
    check("blk_delivered", exp_q.size(), 0);
    check("blk_addr", di_reg_addr, 16'h010A);
    check("blk_oe", data_oe, 1);
    check("blk_underrun_flag", rdy[1], 1);
    state = ST_IDLE; ctl = '0; cyc(3);

    // Backpressure, then underrun on the fifth pop
    host_write(ST_SETEP, 16'h0007);
    check("err_cleared", rdy[1], 0);
    host_write(ST_SETTC_LO, 16'd8);
    snap = rd_cnt;
    state = ST_RDDATA; ctl = 3'b000; cyc(2);
    ctl = 3'b100; cyc(10);
    check("bp_reads", rd_cnt - snap, 4);
    check("bp_rdy0", rdy[0], 1);
    di_read_rdy = 1'b0; cyc(1);
    for (int i = 1; i <= 5; i++) begin
      ctl = 3'b110; cyc(1);
      ctl = 3'b100; cyc(2);
      check($sformatf("pop%0d_err", i), rdy[1], (i == 5) ? 1 : 0);
      check($sformatf("pop%0d_rdy0", i), rdy[0], (i < 4) ? 1 : 0);
    end
    check("bp_delivered", exp_q.size(), 0);
    check("bp_reads_after", rd_cnt - snap, 4);
    state = ST_IDLE; ctl = '0; cyc(3);
    check("err_sticky_idle", rdy[1], 1);
    host_write(ST_SETADDR, 16'h0040);
    check("err_sticky_setaddr", rdy[1], 1);
    host_write(ST_SETEP, 16'h0007);
    check("err_clear_setep", rdy[1], 0);
    in_block = 1'b0;

    // Reset mid-RDDATA with 3 words held, mode previously cleared
    host_write(ST_SETMODE, 16'h0000);
    host_write(ST_SETTC_LO, 16'd3);
    di_read_rdy = 1'b1;
    state = ST_RDDATA; ctl = 3'b000; cyc(2);
    ctl = 3'b100; cyc(8);
    check("pre_rst_rdy0", rdy[0], 1);
    check("pre_rst_oe", data_oe, 1);
    check("pre_rst_term", di_term_addr, 16'h0007);
    #2 resetb = 1'b0;
    #1 check_all_zero("async_rst");
    @(negedge ifclk); resetb = 1'b1; state = ST_IDLE; ctl = '0; cyc(2);
    // 18 terminal reads so far (1 + 10 + 4 + 3), so the next word is 0xB012
    host_write(ST_SETADDR, 16'h0030);
    getrval_read();
    check("post_rst_autoinc", di_reg_addr, 16'h0031);
    check("post_rst_data", data_o, 16'hB012);
    state = ST_IDLE; ctl = '0; cyc(2);

    check("req_read_overlap", overlap_cnt, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
